omem_write_serializer: RTL

- Sits directly downstream of the IO station.
- Accepts its 96-bit OMEM write stream: data row, address row, and an enable held high for 3 cycles per write.
- Buffers each write in a small row FIFO.
- Drains the FIFO as 32-bit word writes to the external OMEM port using a request/acknowledge handshake, so a slow memory never loses IO-station writes until the FIFO is full.

---
 rtl/omem_write_serializer_pkg.sv | 27 ++
 rtl/omem_row_fifo.sv | 49 ++++
 rtl/omem_write_serializer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/omem_write_serializer_pkg.sv
// Shared definitions for the OMEM write serializer: word width, row derivation, drain states.
// OMEM_WRITE_MASK_EN: when defined, words whose address word is all ones are skipped.
package omem_write_serializer_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned ROW_WORDS  = 3;

    // Masked address is a word of all ones, whatever the word width.
    localparam logic MASK_FILL = 1'b1;

`ifdef OMEM_WRITE_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StNext
    } drain_state_e;

    function automatic int unsigned row_width(input int unsigned word_w);
        return ROW_WORDS * word_w;
    endfunction

endpackage

// File: rtl/omem_row_fifo.sv
// Synchronous row FIFO with async active-high reset; a pop in the same cycle frees a full slot.
module omem_row_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 192
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/omem_write_serializer.sv
// Buffers 3-word OMEM row writes from the IO station and drains them as single-word
// request/ack writes. OMEM_WRITE_MASK_EN: skip words with an all-ones address.
module omem_write_serializer
    import omem_write_serializer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [3*WORD_W-1:0]     iOMEMWriteAddress,
    input  logic [3*WORD_W-1:0]     iOMEMWriteData,
    input  logic                    iOMEMWriteEnable,
    output logic [WORD_W-1:0]       oMEMAddress,
    output logic [WORD_W-1:0]       oMEMData,
    output logic                    oMEMWriteRequest,
    input  logic                    iMEMWriteAck,
    output logic                    oFull,
    output logic                    oEmpty,
    output logic                    oOverflow
);

    localparam int unsigned ROW_W = row_width(WORD_W);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]         phase_q;
    logic               push, pop, fifo_full, fifo_empty, overflow_q;
    logic [CNT_W-1:0]   fifo_count;
    logic [2*ROW_W-1:0] head;
    logic [ROW_W-1:0]   head_addr, head_data;
    logic [WORD_W-1:0]  word_addr, word_data;
    logic               word_skip;
    drain_state_e       state_q, state_d;
    logic [1:0]         k_q, k_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            phase_q <= '0;
        end else if (!iOMEMWriteEnable || phase_q == 2'd2) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 2'd1;
        end
    end

    assign push = iOMEMWriteEnable && (phase_q == 2'd0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    omem_row_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * ROW_W)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .wdata ({iOMEMWriteAddress, iOMEMWriteData}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_addr = head[2*ROW_W-1:ROW_W];
    assign head_data = head[ROW_W-1:0];

    // Word 0 lives in the most significant slice of a row.
    always_comb begin
        case (k_q)
            2'd0: begin
                word_addr = head_addr[3*WORD_W-1:2*WORD_W];
                word_data = head_data[3*WORD_W-1:2*WORD_W];
            end
            2'd1: begin
                word_addr = head_addr[2*WORD_W-1:WORD_W];
                word_data = head_data[2*WORD_W-1:WORD_W];
            end
            default: begin
                word_addr = head_addr[WORD_W-1:0];
                word_data = head_data[WORD_W-1:0];
            end
        endcase
    end

    assign word_skip = MASK_EN && (word_addr == {WORD_W{MASK_FILL}});

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // A push seen in IDLE/NEXT starts the drain so the first request follows the capture cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty || push) begin
                    state_d = StReq;
                    k_d     = '0;
                end
            end
            StReq: begin
                if (word_skip || iMEMWriteAck) begin
                    if (k_q == 2'd2) begin
                        pop     = 1'b1;
                        state_d = StNext;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            StNext: begin
                state_d = (!fifo_empty || push) ? StReq : StIdle;
                k_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        oMEMWriteRequest = 1'b0;
        oMEMAddress      = '0;
        oMEMData         = '0;
        if (state_q == StReq && !word_skip) begin
            oMEMWriteRequest = 1'b1;
            oMEMAddress      = word_addr;
            oMEMData         = word_data;
        end
    end

    assign oFull     = fifo_full;
    assign oEmpty    = (fifo_count == '0) && (state_q == StIdle);
    assign oOverflow = overflow_q;

endmodule
